// File: rtl/sample_stream_tx_pkg.sv
// Shared definitions for the packed sample stream {p[1:0],t[1:0],y[1:0],x[1:0]}.
// Used by the transmitter and by the windowed averager that unpacks the same words.
package sample_stream_tx_pkg;

  localparam logic [1:0] P_VALID = 2'b11;
  localparam logic [1:0] P_IDLE  = 2'b00;

  localparam int X_LSB = 0;
  localparam int Y_LSB = 2;
  localparam int T_LSB = 4;
  localparam int P_LSB = 6;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BURST = ST_BURST,
    GAP   = ST_GAP
  } state_e;

  // Buffered sample as stored in the FIFO; bit layout matches the low 6 bits of a word.
  typedef struct packed {
    logic [1:0] t;
    logic [1:0] y;
    logic [1:0] x;
  } sample_t;

  localparam logic [7:0] IDLE_WORD = {P_IDLE, 6'b00_0000};

  function automatic logic [7:0] pack_word(input sample_t s);
    logic [7:0] w;
    w = '0;
    w[P_LSB +: 2] = P_VALID;
    w[T_LSB +: 2] = s.t;
    w[Y_LSB +: 2] = s.y;
    w[X_LSB +: 2] = s.x;
    return w;
  endfunction

endpackage

// File: rtl/sample_stream_tx_fifo.sv
// Small synchronous FIFO with registered pointers and a combinational head read.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  // full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_stream_tx.sv
// Transmit side of the packed sample stream: buffers x/y/t samples and emits
// bursts of WINDOW_SIZE word slots separated by a programmable idle gap.
module sample_stream_tx
  import sample_stream_tx_pkg::*;
#(
  parameter int WINDOW_SIZE = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int GAP_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_x,
  input  logic [1:0]       in_y,
  input  logic [1:0]       in_t,
  input  logic [GAP_W-1:0] gap_cfg,
  input  logic             flush,
  output logic [7:0]       uo_out,
  output logic             busy,
  output logic [7:0]       underrun,
  output state_e           state_dbg
);

  // Handshake: a sample transfers on a posedge where in_valid && in_ready;
  // in_ready depends only on registered FIFO occupancy; flush drops the sample.

  localparam int SW = $clog2(WINDOW_SIZE + 1);
  localparam logic [SW-1:0] LAST_SLOT = SW'(WINDOW_SIZE);

  state_e           state;
  state_e           state_nxt;
  logic [SW-1:0]    slot;
  logic [SW-1:0]    slot_nxt;
  logic [SW-1:0]    slot_inc;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nxt;
  logic [7:0]       word_nxt;
  logic             emit;
  logic             und_inc;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  sample_t          head;

  sync_fifo #(
    .WIDTH ($bits(sample_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_n),
    .clear (flush),
    .push  (in_valid && !flush),
    .pop   (pop),
    .din   ({in_t, in_y, in_x}),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign state_dbg = state;
  assign slot_inc  = slot + SW'(1);

  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    gap_nxt   = gap_cnt;
    word_nxt  = IDLE_WORD;
    emit      = 1'b0;
    und_inc   = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          emit      = 1'b1;
          pop       = 1'b1;
          word_nxt  = pack_word(head);
          slot_nxt  = slot_inc;
          state_nxt = BURST;
        end
      end
      BURST: begin
        emit     = 1'b1;
        slot_nxt = slot_inc;
        if (!fifo_empty) begin
          pop      = 1'b1;
          word_nxt = pack_word(head);
        end else begin
          und_inc = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) begin
          state_nxt = IDLE;
          gap_nxt   = '0;
        end else begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // The slot just emitted closes the window: go to the gap, or straight back to IDLE.
    if (emit && (slot_inc == LAST_SLOT)) begin
      slot_nxt = '0;
      if (gap_cfg != '0) begin
        state_nxt = GAP;
        gap_nxt   = gap_cfg;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      slot     <= '0;
      gap_cnt  <= '0;
      uo_out   <= IDLE_WORD;
      busy     <= 1'b0;
      underrun <= '0;
    end else if (flush) begin
      state   <= IDLE;
      slot    <= '0;
      gap_cnt <= '0;
      uo_out  <= IDLE_WORD;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      slot    <= slot_nxt;
      gap_cnt <= gap_nxt;
      uo_out  <= word_nxt;
      busy    <= (state_nxt != IDLE);
      if (und_inc && (underrun != 8'hFF)) begin
        underrun <= underrun + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_sample_stream_tx.sv
// Self-checking bench for sample_stream_tx: scenario tasks with inline checks plus
// a scoreboard that matches every valid output word against an expected queue.
module tb_sample_stream_tx;

  localparam int WS = 4;
  localparam int FD = 4;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_x;
  logic [1:0]    in_y;
  logic [1:0]    in_t;
  logic [GW-1:0] gap_cfg;
  logic          flush;
  logic [7:0]    uo_out;
  logic          busy;
  logic [7:0]    underrun;
  logic [1:0]    state_dbg;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_underrun = 8'h00;

  // Inputs change and outputs are sampled on the negedge, half a period from the active edge.
  always #5 clk = ~clk;

  sample_stream_tx #(
    .WINDOW_SIZE (WS),
    .FIFO_DEPTH  (FD),
    .GAP_W       (GW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_t      (in_t),
    .gap_cfg   (gap_cfg),
    .flush     (flush),
    .uo_out    (uo_out),
    .busy      (busy),
    .underrun  (underrun),
    .state_dbg (state_dbg)
  );

  function automatic logic [7:0] model_word(input logic [1:0] x, input logic [1:0] y,
                                            input logic [1:0] t);
    return {2'b11, t, y, x};
  endfunction

  task automatic drive_sample(input logic [1:0] x, input logic [1:0] y, input logic [1:0] t,
                              input bit expect_out);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    in_t = t;
    if (in_ready && expect_out) exp_q.push_back(model_word(x, y, t));
  endtask

  task automatic scoreboard_monitor();
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (uo_out[7:6] === 2'b11) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL scoreboard_unexpected: got %h, queue empty", uo_out);
        end else begin
          want = exp_q.pop_front();
          if (uo_out !== want) $display("FAIL scoreboard_word: got %h want %h", uo_out, want);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++; if (uo_out !== 8'h00) $display("FAIL reset_uo_out c%0d: got %h want 00", i, uo_out); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy c%0d: got %b want 0", i, busy); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready c%0d: got %b want 1", i, in_ready); else n_pass++;
      n_checks++; if (underrun !== 8'h00) $display("FAIL reset_underrun c%0d: got %h want 00", i, underrun); else n_pass++;
      n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state c%0d: got %0d want 0", i, state_dbg); else n_pass++;
    end
  endtask

  task automatic test_full_burst();
    logic [1:0] sx[4];
    logic [1:0] sy[4];
    logic [1:0] st[4];
    logic [7:0] want;
    logic       want_busy;
    sx = '{2'd1, 2'd3, 2'd0, 2'd2};
    sy = '{2'd2, 2'd3, 2'd1, 2'd0};
    st = '{2'd3, 2'd3, 2'd2, 2'd1};
    gap_cfg = 4'd2;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive_sample(sx[i], sy[i], st[i], 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      want = 8'h00;
      if (i >= 1 && i <= 4) want = model_word(sx[i-1], sy[i-1], st[i-1]);
      want_busy = (i >= 1 && i <= 5);
      n_checks++; if (uo_out !== want) $display("FAIL burst_uo_out c%0d: got %h want %h", i, uo_out, want); else n_pass++;
      n_checks++; if (busy !== want_busy) $display("FAIL burst_busy c%0d: got %b want %b", i, busy, want_busy); else n_pass++;
    end
  endtask

  task automatic test_underrun();
    logic [7:0] want;
    logic [7:0] want_und;
    gap_cfg = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) drive_sample(2'd1, 2'd1, 2'd1, 1'b1);
      else in_valid = 1'b0;
      @(negedge clk);
      want = (i == 1) ? model_word(2'd1, 2'd1, 2'd1) : 8'h00;
      want_und = exp_underrun;
      if (i >= 2) want_und = exp_underrun + 8'((i - 1 > 3) ? 3 : i - 1);
      n_checks++; if (uo_out !== want) $display("FAIL underrun_uo_out c%0d: got %h want %h", i, uo_out, want); else n_pass++;
      n_checks++; if (busy !== (i >= 1 && i <= 3)) $display("FAIL underrun_busy c%0d: got %b", i, busy); else n_pass++;
      n_checks++; if (underrun !== want_und) $display("FAIL underrun_count c%0d: got %h want %h", i, underrun, want_und); else n_pass++;
    end
    exp_underrun = exp_underrun + 8'd3;
  endtask

  task automatic test_backpressure();
    int acc;
    int seen;
    int level;
    bit saw_full;
    bit took;
    int waited;
    acc = 0;
    seen = 0;
    saw_full = 1'b0;
    gap_cfg = 4'd15;
    in_x = 2'($urandom_range(0, 3));
    in_y = 2'($urandom_range(0, 3));
    in_t = 2'($urandom_range(0, 3));
    in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      took = in_ready;
      if (took) begin
        exp_q.push_back(model_word(in_x, in_y, in_t));
        acc++;
      end
      @(negedge clk);
      if (uo_out[7:6] === 2'b11) seen++;
      level = acc - seen;
      if (level == FD) saw_full = 1'b1;
      n_checks++; if (in_ready !== (level != FD)) $display("FAIL bp_in_ready c%0d: got %b with %0d queued", i, in_ready, level); else n_pass++;
      if (took) begin
        in_x = 2'($urandom_range(0, 3));
        in_y = 2'($urandom_range(0, 3));
        in_t = 2'($urandom_range(0, 3));
      end
    end
    in_valid = 1'b0;
    waited = 0;
    while (seen < acc && waited < 100) begin
      @(negedge clk);
      if (uo_out[7:6] === 2'b11) seen++;
      waited++;
    end
    n_checks++; if (seen != acc) $display("FAIL bp_drain: got %0d words want %0d", seen, acc); else n_pass++;
    n_checks++; if (!saw_full) $display("FAIL bp_full_seen: got 0 want 1"); else n_pass++;
    waited = 0;
    while (busy !== 1'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (busy !== 1'b0) $display("FAIL bp_idle_timeout: got busy %b want 0", busy); else n_pass++;
    n_checks++; if (underrun !== exp_underrun) $display("FAIL bp_underrun: got %h want %h", underrun, exp_underrun); else n_pass++;
  endtask

  task automatic test_flush();
    logic [1:0] sx[4];
    logic [7:0] want;
    sx = '{2'd2, 2'd1, 2'd3, 2'd0};
    gap_cfg = 4'd2;
    for (int i = 0; i < 8; i++) begin
      flush = (i == 3);
      // Only the two samples emitted before the flush ever reach the output.
      if (i < 4) drive_sample(sx[i], ~sx[i], sx[i] ^ 2'd1, i < 2);
      else in_valid = 1'b0;
      @(negedge clk);
      want = 8'h00;
      if (i == 1 || i == 2) want = model_word(sx[i-1], ~sx[i-1], sx[i-1] ^ 2'd1);
      n_checks++; if (uo_out !== want) $display("FAIL flush_uo_out c%0d: got %h want %h", i, uo_out, want); else n_pass++;
      if (i == 3) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL flush_state: got %0d want 0", state_dbg); else n_pass++;
        n_checks++; if (underrun !== exp_underrun) $display("FAIL flush_underrun: got %h want %h", underrun, exp_underrun); else n_pass++;
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_reset_mid_gap();
    logic [7:0] want;
    gap_cfg = 4'd15;
    for (int i = 0; i < 18; i++) begin
      rst_n = (i == 7);
      if (i < 6) drive_sample(2'(i), 2'(i + 1), 2'(i + 2), i < 4);
      else in_valid = 1'b0;
      @(negedge clk);
      want = 8'h00;
      if (i >= 1 && i <= 4) want = model_word(2'(i - 1), 2'(i), 2'(i + 1));
      n_checks++; if (uo_out !== want) $display("FAIL rstgap_uo_out c%0d: got %h want %h", i, uo_out, want); else n_pass++;
      if (i == 6) begin
        n_checks++; if (state_dbg !== 2'd2) $display("FAIL rstgap_in_gap: got %0d want 2", state_dbg); else n_pass++;
      end
      if (i == 7) begin
        n_checks++; if (busy !== 1'b0) $display("FAIL rstgap_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rstgap_in_ready: got %b want 1", in_ready); else n_pass++;
        n_checks++; if (underrun !== 8'h00) $display("FAIL rstgap_underrun: got %h want 00", underrun); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL rstgap_state: got %0d want 0", state_dbg); else n_pass++;
      end
    end
    exp_underrun = 8'h00;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_x = 2'd0;
    in_y = 2'd0;
    in_t = 2'd0;
    gap_cfg = '0;
    flush = 1'b0;
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_full_burst();
    test_underrun();
    test_backpressure();
    test_flush();
    test_reset_mid_gap();
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
